// File: rtl/gun_unit.sv
// Player weapon block: maps mouse bins to a screen aim point, fires on the left
// button with a fixed cooldown, and flags crosshair pixels for the VGA pipeline.
module gun_unit #(
   parameter int unsigned BIN_W     = 6,
   parameter int unsigned BIN_SIZE  = 10,
   parameter int unsigned CD_TICKS  = 19_999_999,
   parameter int unsigned CNT_W     = $clog2(CD_TICKS),
   parameter int unsigned XH_RADIUS = 32,
   parameter int unsigned MAX_H     = 480
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [9:0]       x,
   input  logic [8:0]       y,
   input  logic [BIN_W-1:0] bin_x,
   input  logic [BIN_W-1:0] bin_y,
   input  logic             button_left,
   output logic [9:0]       shoot_x,
   output logic [8:0]       shoot_y,
   output logic             shot,
   output logic             render,
   output logic             cd
);

   localparam int unsigned XW    = 10;
   localparam int unsigned YW    = 9;
   localparam int unsigned BOX   = 2 * XH_RADIUS;
   localparam int unsigned RW    = $clog2(BOX);
   localparam int unsigned SQW   = 2 * RW + 3;
   localparam int unsigned GAP_L = XH_RADIUS - 4;
   localparam int unsigned GAP_H = XH_RADIUS + 3;
   localparam int unsigned RIN2  = (XH_RADIUS - 4) * (XH_RADIUS - 4);
   localparam int unsigned ROUT2 = (XH_RADIUS - 2) * (XH_RADIUS - 2);

   typedef enum logic {IDLE, CD} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic [XW-1:0] cx, tx, dx;
   logic [YW-1:0] cy, ty, dy;
   logic          in_box, on_axis, in_gap, arm, ring;
   logic signed [RW:0]    rx, ry;
   logic signed [SQW-1:0] rxe, rye, r2;

   logic unused_start;
   assign unused_start = start;

   // Aim point; mouse y grows upward so it is flipped against the screen height.
   assign cx      = XW'(32'(bin_x) * BIN_SIZE);
   assign cy      = YW'(32'(MAX_H) - 32'(bin_y) * BIN_SIZE);
   assign shoot_x = cx;
   assign shoot_y = cy;
   assign tx      = cx - XW'(XH_RADIUS);
   assign ty      = cy - YW'(XH_RADIUS);

   assign shot = (state == IDLE) && button_left;
   assign cd   = (state == CD);

   // Fire/cooldown controller with its saturating cycle counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE:    if (shot) state <= CD;
            CD:      if (cnt == CNT_W'(CD_TICKS)) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (shot)
            cnt <= '0;
         else if (state == CD && cnt != CNT_W'(CD_TICKS))
            cnt <= cnt + CNT_W'(1);
      end
   end

   // Pixel offset from the crosshair's top-left corner; edges wrap modulo the screen.
   assign dx     = x - tx;
   assign dy     = y - ty;
   assign in_box = (dx < XW'(BOX)) && (dy < YW'(BOX));

   assign on_axis = (dx == XW'(XH_RADIUS - 1)) || (dx == XW'(XH_RADIUS)) ||
                    (dy == YW'(XH_RADIUS - 1)) || (dy == YW'(XH_RADIUS));
   assign in_gap  = (dx >= XW'(GAP_L)) && (dx <= XW'(GAP_H)) &&
                    (dy >= YW'(GAP_L)) && (dy <= YW'(GAP_H));
   assign arm     = on_axis && !in_gap;

   // Ring term only matters inside the box, so the low offset bits suffice.
   assign rx   = $signed({1'b0, dx[RW-1:0]}) - $signed((RW+1)'(XH_RADIUS));
   assign ry   = $signed({1'b0, dy[RW-1:0]}) - $signed((RW+1)'(XH_RADIUS));
   assign rxe  = {{(RW+2){rx[RW]}}, rx};
   assign rye  = {{(RW+2){ry[RW]}}, ry};
   assign r2   = rxe * rxe + rye * rye;
   assign ring = (r2 >= $signed(SQW'(RIN2))) && (r2 <= $signed(SQW'(ROUT2)));

   always_ff @(posedge clk) begin
      if (reset) render <= 1'b0;
      else       render <= in_box && (arm || ring);
   end

endmodule

// File: tb/tb_gun_unit.sv
// Self-checking bench for gun_unit: vector table for aim/crosshair pixels,
// hand-built cooldown sequences, and randomized runs against a reference model.
module tb_gun_unit;

   localparam int CDT = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [9:0] x = '0;
   logic [8:0] y = '0;
   logic [5:0] bin_x = '0;
   logic [5:0] bin_y = '0;
   logic       button_left = 1'b0;
   logic [9:0] shoot_x;
   logic [8:0] shoot_y;
   logic       shot, render, cd;

   int total = 0;
   int bad   = 0;

   gun_unit #(.CD_TICKS(CDT)) dut (
      .clk(clk), .reset(reset), .start(start), .x(x), .y(y),
      .bin_x(bin_x), .bin_y(bin_y), .button_left(button_left),
      .shoot_x(shoot_x), .shoot_y(shoot_y), .shot(shot),
      .render(render), .cd(cd)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    bx, by, px, py;
      int    sx, sy, rnd;
      string name;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int wrap(input int v, input int m);
      return ((v % m) + m) % m;
   endfunction

   function automatic int m_cx(input int bx);
      return wrap(bx * 10, 1024);
   endfunction

   function automatic int m_cy(input int by);
      return wrap(480 - by * 10, 512);
   endfunction

   // Crosshair shape from its geometric definition: box, plus-arms with gap, ring.
   function automatic int m_render(input int bx, input int by, input int px, input int py);
      int dx, dy, r2;
      bit box, arm, gap, ring;
      dx   = wrap(px - (m_cx(bx) - 32), 1024);
      dy   = wrap(py - (m_cy(by) - 32), 512);
      box  = (dx < 64) && (dy < 64);
      gap  = (dx >= 28 && dx <= 35) && (dy >= 28 && dy <= 35);
      arm  = (dx == 31 || dx == 32 || dy == 31 || dy == 32) && !gap;
      r2   = (dx - 32) * (dx - 32) + (dy - 32) * (dy - 32);
      ring = (r2 >= 28 * 28) && (r2 <= 30 * 30);
      return (box && (arm || ring)) ? 1 : 0;
   endfunction

   task automatic expect_cd_run(input string tag);
      for (int i = 1; i <= CDT + 1; i++) begin
         #1;
         chk({tag, "_cd"}, int'(cd), 1);
         chk({tag, "_noshot"}, int'(shot), 0);
         tick();
      end
      #1;
      chk({tag, "_cd_end"}, int'(cd), 0);
   endtask

   vec_t vecs[15];

   initial begin
      int busy;
      bit exp_shot;

      vecs[0]  = '{6, 9, 60, 380, 60, 390, 1, "arm_vertical"};
      vecs[1]  = '{6, 9, 60, 390, 60, 390, 0, "centre_gap"};
      vecs[2]  = '{6, 9, 30, 390, 60, 390, 1, "ring_r900"};
      vecs[3]  = '{6, 9, 200, 100, 60, 390, 0, "far_pixel"};
      vecs[4]  = '{0, 0, 0, 480, 0, 480, 0, "origin_gap"};
      vecs[5]  = '{0, 0, 0, 460, 0, 480, 1, "origin_arm"};
      vecs[6]  = '{6, 9, 60, 358, 60, 390, 1, "arm_top_edge"};
      vecs[7]  = '{6, 9, 92, 390, 60, 390, 0, "box_right_out"};
      vecs[8]  = '{6, 9, 91, 390, 60, 390, 1, "box_right_in"};
      vecs[9]  = '{0, 0, 1000, 480, 0, 480, 1, "wrap_x_arm"};
      vecs[10] = '{63, 63, 630, 332, 630, 362, 1, "wrap_y_arm"};
      vecs[11] = '{6, 9, 42, 366, 60, 390, 1, "ring_only"};
      vecs[12] = '{6, 9, 41, 366, 60, 390, 0, "ring_outside"};
      vecs[13] = '{6, 9, 63, 390, 60, 390, 0, "gap_edge"};
      vecs[14] = '{6, 9, 64, 390, 60, 390, 1, "arm_past_gap"};

      // Reset with a pixel that would otherwise render.
      bin_x = 6; bin_y = 9; x = 60; y = 380;
      tick(); tick();
      chk("reset_render", int'(render), 0);
      chk("reset_cd", int'(cd), 0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         bin_x = 6'(vecs[i].bx); bin_y = 6'(vecs[i].by);
         x = 10'(vecs[i].px);    y = 9'(vecs[i].py);
         #1;
         chk({vecs[i].name, "_sx"}, int'(shoot_x), vecs[i].sx);
         chk({vecs[i].name, "_sy"}, int'(shoot_y), vecs[i].sy);
         tick();
         chk({vecs[i].name, "_render"}, int'(render), vecs[i].rnd);
      end

      // Held button: fires, cools down CDT+1 cycles, re-fires on first idle cycle.
      button_left = 1'b1;
      #1;
      chk("held_first_shot", int'(shot), 1);
      chk("held_first_cd", int'(cd), 0);
      tick();
      expect_cd_run("held");
      chk("held_refire", int'(shot), 1);
      tick();

      // Press and release during cooldown: ignored and does not extend it.
      button_left = 1'b0;
      for (int i = 1; i <= CDT + 1; i++) begin
         button_left = (i == 2 || i == 3);
         #1;
         chk("tap_cd", int'(cd), 1);
         chk("tap_noshot", int'(shot), 0);
         tick();
      end
      button_left = 1'b0;
      #1;
      chk("tap_cd_end", int'(cd), 0);
      chk("tap_idle_noshot", int'(shot), 0);

      // Reset mid-cooldown: idle next cycle, and the next cooldown is full length.
      button_left = 1'b1;
      tick();
      button_left = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_cd", int'(cd), 0);
      chk("midrst_noshot", int'(shot), 0);
      button_left = 1'b1;
      #1;
      chk("midrst_shot", int'(shot), 1);
      tick();
      button_left = 1'b0;
      expect_cd_run("midrst");

      // Randomized aim and crosshair pixels near the aim point.
      for (int i = 0; i < 300; i++) begin
         int bx, by, px, py;
         bx = int'($urandom_range(0, 63));
         by = int'($urandom_range(0, 63));
         px = wrap(m_cx(bx) + int'($urandom_range(0, 80)) - 40, 1024);
         py = wrap(m_cy(by) + int'($urandom_range(0, 80)) - 40, 512);
         bin_x = 6'(bx); bin_y = 6'(by); x = 10'(px); y = 9'(py);
         start = 1'($urandom_range(0, 1));
         #1;
         chk("rnd_sx", int'(shoot_x), m_cx(bx));
         chk("rnd_sy", int'(shoot_y), m_cy(by));
         tick();
         chk("rnd_render", int'(render), m_render(bx, by, px, py));
      end

      // Randomized button/reset traffic against a remaining-cooldown model.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      busy = 0;
      for (int i = 0; i < 600; i++) begin
         button_left = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 40) == 0);
         #1;
         exp_shot = (busy == 0) && button_left;
         chk("rnd_cd", int'(cd), (busy > 0) ? 1 : 0);
         chk("rnd_shot", int'(shot), exp_shot ? 1 : 0);
         if (reset)         busy = 0;
         else if (exp_shot) busy = CDT + 1;
         else if (busy > 0) busy--;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gun_unit.md
Name: gun_unit

Overview:
- Player weapon block for the shooter game.
- Converts a binned mouse position into screen coordinates and generates a fire pulse on the left button.
- Enforces a fixed cooldown after each shot.
- Drives a per-pixel crosshair render flag for the VGA pixel pipeline.
- Contains two internal sub-functions: a cooldown up-counter and a crosshair pixel renderer.

Parameters:
- BIN_W, 6, width of the bin_x/bin_y mouse bin coordinates.
- BIN_SIZE, 10, screen pixels per mouse bin.
- CD_TICKS, 19_999_999, cooldown terminal count in clk cycles (0.4 s at 50 MHz).
- CNT_W, $clog2(CD_TICKS) (25 at default), cooldown counter width.
- XH_RADIUS, 32, crosshair half-size in pixels.
- MAX_H, 480, screen height used for the y inversion.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset; clock clk.
- start, in, 1, reserved; ignored.
- x, in, 10, current VGA pixel column.
- y, in, 9, current VGA pixel row.
- bin_x, in, BIN_W, mouse x bin.
- bin_y, in, BIN_W, mouse y bin; mouse y grows upward.
- button_left, in, 1, left mouse button level.
- shoot_x, out, 10, crosshair centre x in screen pixels.
- shoot_y, out, 9, crosshair centre y in screen pixels.
- shot, out, 1, fire pulse.
- render, out, 1, current pixel belongs to the crosshair.
- cd, out, 1, high while in cooldown.

Behaviour:
- Coordinates (combinational, modular truncation, no clamping):
  - cx = (bin_x*BIN_SIZE) mod 2^10.
  - cy = (MAX_H - bin_y*BIN_SIZE) mod 2^9.
  - shoot_x = cx; shoot_y = cy.
  - Top-left: tx = (cx - XH_RADIUS) mod 2^10; ty = (cy - XH_RADIUS) mod 2^9.
- FSM states: IDLE, CD. Reset → IDLE.
  - IDLE → CD when shot.
  - CD → IDLE when counter == CD_TICKS.
- shot = (state==IDLE) & button_left. Combinational, so it follows button_left in the same cycle.
  - Holding the button re-fires on the first IDLE cycle after cooldown.
  - Button activity during CD is ignored.
- cd = (state==CD).
- Cooldown counter:
  - CNT_W bits; synchronous clear when reset or shot.
  - Otherwise increments by 1 each cycle the state is CD.
  - Saturates (holds) at CD_TICKS and never wraps.
  - Clear has priority over increment.
- Cooldown timing:
  - Counter is 0 on the first CD cycle, so CD lasts exactly CD_TICKS+1 cycles.
  - The next shot is possible on the following cycle.
- Reset mid-cooldown: state → IDLE and counter → 0 on the next edge.
- Reset values: state IDLE, counter 0, render 0; cd 0 after reset. shot and shoot_x/shoot_y are combinational.
- Crosshair renderer (render registered, 1-cycle latency from x/y):
  - dx = (x - tx) mod 2^10; dy = (y - ty) mod 2^9.
  - in_box = dx < 2*XH_RADIUS and dy < 2*XH_RADIUS.
  - arm = (dx ∈ {31,32} or dy ∈ {31,32}) and not (dx ∈ [28,35] and dy ∈ [28,35]), i.e. a plus sign with a central gap.
  - ring: r2 = (dx-32)^2 + (dy-32)^2 in signed arithmetic, with 784 ≤ r2 ≤ 900 (radius 28..30).
  - render <= in_box & (arm | ring).
- Wrap-around: crosshairs near the screen edges wrap via the modular dx/dy. This is accepted behaviour.

Test Plan:
- bin_x=6, bin_y=9 → shoot_x=60, shoot_y=390 (combinational). bin_x=0, bin_y=0 → shoot_x=0, shoot_y=480.
- After reset, IDLE with button_left=1 → shot=1 in the same cycle. Next edge: cd=1, shot=0, even with button held.
- With CD_TICKS=5: shot at cycle n → cd=1 for cycles n+1..n+6. IDLE at n+7; with button held, shot=1 at n+7.
- Reset asserted mid-CD → next cycle cd=0, counter=0; shot follows button_left immediately.
- bin_x=6, bin_y=9 (tx=28, ty=358):
  - pixel (60,380) → render=1 one cycle later (vertical arm, dy=22).
  - pixel (60,390) → render=0 (central gap).
  - pixel (30,390), dx=2 → render=1 (ring, r2=900).
  - pixel (200,100) → render=0.
- Button pressed and released within CD → no shot, and the cooldown is not extended.
